w_wnd_comp: RTL and testbench

W_WND_COMP -- requirements
Module: w_wnd_comp

---
 rtl/w_wnd_comp_if.sv | 34 +++
 rtl/w_wnd_comp.sv | 227 ++++++++++++++++++++++
 tb/tb_w_wnd_comp.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/w_wnd_comp_if.sv
// w_wnd_comp_if -- bus between the SHA-256 round engine and its host.
//
// Signals:
//   cmd     host -> engine  command code, sampled by the engine only in IDLE
//   mka     engine -> host  round index t; host returns W-source word and K[t]
//   md      host -> engine  message word (t mod 16), combinational from mka
//   kd      host -> engine  round constant K[t], combinational from mka
//   ha      engine -> host  H-store word address
//   hd_in   host -> engine  H-store word at ha, combinational from ha
//   hd_out  engine -> host  hd_in + working register selected by ha[2:0]
//   rdy     engine -> host  command complete (level)
//
// Modports: master = host side, slave = engine side.

interface w_wnd_comp_if;
    logic [7:0]  cmd;
    logic [7:0]  mka;
    logic [31:0] md;
    logic [31:0] kd;
    logic [7:0]  ha;
    logic [31:0] hd_in;
    logic [31:0] hd_out;
    logic        rdy;

    modport master (
        output cmd, md, kd, hd_in,
        input  mka, ha, hd_out, rdy
    );

    modport slave (
        input  cmd, md, kd, hd_in,
        output mka, ha, hd_out, rdy
    );
endinterface

// File: rtl/w_wnd_comp.sv
// w_wnd_comp -- SHA-256 compression engine with a 16-word sliding message
// schedule window. The host supplies message words, round constants and the
// H store through a combinational lookup addressed by mka / ha.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   reset_n  synchronous active-low reset
//   bus      w_wnd_comp_if.slave (cmd, mka, md, kd, ha, hd_in, hd_out, rdy)
//
// Commands (cmd, sampled in IDLE only):
//   0 IDLE       no operation; releases DONE
//   1 LOAD_H     a..h <= H store words 0..7
//   2 HASH       64 compression rounds on a..h
//   3 SUM_STORE  present H[i] + reg[i] on hd_out for i = 0..7
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a recognised command; rdy low
// LOAD  | ha steps 0..7, one H word loaded into a..h per cycle
// HASH  | mka steps 0..63, one compression round per cycle
// SUM   | ha steps 0..7, each address held one cycle for hd_out capture
// DONE  | rdy high; waits for cmd == IDLE

module w_wnd_comp (
    input  logic         clk,
    input  logic         reset_n,
    w_wnd_comp_if.slave  bus
);

    localparam logic [7:0] CMD_IDLE      = 8'd0;
    localparam logic [7:0] CMD_LOAD_H    = 8'd1;
    localparam logic [7:0] CMD_HASH      = 8'd2;
    localparam logic [7:0] CMD_SUM_STORE = 8'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HASH = 3'd2,
        S_SUM  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state;
    logic        rdy_q;
    logic [7:0]  mka_q;
    logic [7:0]  ha_q;

    // Working registers, named a..h so they can be probed hierarchically.
    logic [31:0] a, b, c, d, e, f, g, h;

    // Message schedule window: w_win[15] is W(t-1), w_win[0] is W(t-16).
    logic [31:0] w_win [16];

    // ------------------------------------------------------------------
    // SHA-256 helper functions
    // ------------------------------------------------------------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    // ------------------------------------------------------------------
    // Round datapath
    // ------------------------------------------------------------------
    logic [31:0] w_sched;
    logic [31:0] w_t;
    logic [31:0] ch_efg;
    logic [31:0] maj_abc;
    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        w_sched = sig1(w_win[14]) + w_win[9] + sig0(w_win[1]) + w_win[0];
        // The first 16 rounds take the message word straight from the host.
        w_t     = (mka_q < 8'd16) ? bus.md : w_sched;
        ch_efg  = (e & f) ^ (~e & g);
        maj_abc = (a & b) ^ (a & c) ^ (b & c);
        t1      = h + bsig1(e) + ch_efg + bus.kd + w_t;
        t2      = bsig0(a) + maj_abc;
    end

    // ------------------------------------------------------------------
    // H-store adder: hd_in plus the register picked by ha[2:0]
    // ------------------------------------------------------------------
    logic [31:0] reg_sel;

    always_comb begin
        reg_sel = a;
        case (ha_q[2:0])
            3'd0:    reg_sel = a;
            3'd1:    reg_sel = b;
            3'd2:    reg_sel = c;
            3'd3:    reg_sel = d;
            3'd4:    reg_sel = e;
            3'd5:    reg_sel = f;
            3'd6:    reg_sel = g;
            default: reg_sel = h;
        endcase
    end

    assign bus.hd_out = bus.hd_in + reg_sel;
    assign bus.mka    = mka_q;
    assign bus.ha     = ha_q;
    assign bus.rdy    = rdy_q;

    // ------------------------------------------------------------------
    // Control FSM and state registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            rdy_q <= 1'b0;
            mka_q <= 8'd0;
            ha_q  <= 8'd0;
            a     <= 32'd0;
            b     <= 32'd0;
            c     <= 32'd0;
            d     <= 32'd0;
            e     <= 32'd0;
            f     <= 32'd0;
            g     <= 32'd0;
            h     <= 32'd0;
            for (int i = 0; i < 16; i++) begin
                w_win[i] <= 32'd0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    rdy_q <= 1'b0;
                    case (bus.cmd)
                        CMD_LOAD_H: begin
                            state <= S_LOAD;
                            ha_q  <= 8'd0;
                        end
                        CMD_HASH: begin
                            state <= S_HASH;
                            mka_q <= 8'd0;
                        end
                        CMD_SUM_STORE: begin
                            state <= S_SUM;
                            ha_q  <= 8'd0;
                        end
                        default: ;
                    endcase
                end

                S_LOAD: begin
                    case (ha_q[2:0])
                        3'd0:    a <= bus.hd_in;
                        3'd1:    b <= bus.hd_in;
                        3'd2:    c <= bus.hd_in;
                        3'd3:    d <= bus.hd_in;
                        3'd4:    e <= bus.hd_in;
                        3'd5:    f <= bus.hd_in;
                        3'd6:    g <= bus.hd_in;
                        default: h <= bus.hd_in;
                    endcase
                    // ha parks on 7 when done; the next LOAD/SUM restarts it.
                    if (ha_q == 8'd7) begin
                        state <= S_DONE;
                        rdy_q <= 1'b1;
                    end else begin
                        ha_q <= ha_q + 8'd1;
                    end
                end

                S_HASH: begin
                    h <= g;
                    g <= f;
                    f <= e;
                    e <= d + t1;
                    d <= c;
                    c <= b;
                    b <= a;
                    a <= t1 + t2;
                    for (int i = 0; i < 15; i++) begin
                        w_win[i] <= w_win[i + 1];
                    end
                    w_win[15] <= w_t;
                    if (mka_q == 8'd63) begin
                        state <= S_DONE;
                        rdy_q <= 1'b1;
                    end else begin
                        mka_q <= mka_q + 8'd1;
                    end
                end

                S_SUM: begin
                    if (ha_q == 8'd7) begin
                        state <= S_DONE;
                        rdy_q <= 1'b1;
                    end else begin
                        ha_q <= ha_q + 8'd1;
                    end
                end

                S_DONE: begin
                    if (bus.cmd == CMD_IDLE) begin
                        rdy_q <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w_wnd_comp.sv
// tb_w_wnd_comp -- directed bench for w_wnd_comp. Provides the host-side
// lookups (message, K table, H store) and checks reset, LOAD, HASH, SUM,
// DONE handshake, ignored commands and a mid-HASH reset.

module tb_w_wnd_comp;

    localparam logic [7:0] CMD_IDLE      = 8'd0;
    localparam logic [7:0] CMD_LOAD_H    = 8'd1;
    localparam logic [7:0] CMD_HASH      = 8'd2;
    localparam logic [7:0] CMD_SUM_STORE = 8'd3;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] MSG [16] = '{
        32'h01000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e,
        32'h67768f61, 32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa
    };

    localparam logic [31:0] H_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] H_HASH [8] = '{
        32'h5286b3cc, 32'ha7f1116b, 32'h545db90b, 32'h7909d56e,
        32'h72ba866a, 32'hb3fb9b3c, 32'h772dad8b, 32'heb392c02
    };

    localparam logic [31:0] H_SUM [8] = '{
        32'hbc909a33, 32'h6358bff0, 32'h90ccac7d, 32'h1e59caa8,
        32'hc3c8d8e9, 32'h4f0103c8, 32'h96b18736, 32'h4719f91b
    };

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    w_wnd_comp_if bus ();

    w_wnd_comp dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] hmem [16];

    assign bus.md    = MSG[bus.mka[3:0]];
    assign bus.kd    = K_TAB[bus.mka[5:0]];
    assign bus.hd_in = hmem[bus.ha[3:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_reg(input int i);
        case (i)
            0:       return dut.a;
            1:       return dut.b;
            2:       return dut.c;
            3:       return dut.d;
            4:       return dut.e;
            5:       return dut.f;
            6:       return dut.g;
            default: return dut.h;
        endcase
    endfunction

    // Drive a command, count negedges until rdy, optionally capture hd_out
    // into the H store, and switch cmd to alt mid-operation (must be ignored).
    task automatic issue(input logic [7:0] code, input logic [7:0] alt,
                         input bit capture, output int lat);
        bus.cmd = code;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (capture && !bus.rdy) hmem[int'(bus.ha[2:0]) + 8] = bus.hd_out;
            if (lat == 5) bus.cmd = alt;
        end while (!bus.rdy && lat < 200);
    endtask

    // Keep the command asserted in DONE, then release with IDLE.
    task automatic hold_release(input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("%s_hold_rdy%0d", tag, i), {31'd0, bus.rdy}, 32'd1);
        end
        bus.cmd = CMD_IDLE;
        @(negedge clk);
        chk($sformatf("%s_release_rdy", tag), {31'd0, bus.rdy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lat;
        bit  seen;
        bit  hit30;

        for (int i = 0; i < 16; i++) hmem[i] = (i < 8) ? H_INIT[i] : 32'd0;
        bus.cmd = CMD_IDLE;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_rdy", {31'd0, bus.rdy}, 32'd0);
        chk("rst_ha",  {24'd0, bus.ha},  32'd0);
        chk("rst_mka", {24'd0, bus.mka}, 32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_reg%0d", i), dut_reg(i), 32'd0);
        reset_n = 1'b1;

        // Unknown command codes are ignored in IDLE
        bus.cmd = 8'hA5;
        repeat (4) @(negedge clk);
        chk("bad_cmd_rdy", {31'd0, bus.rdy}, 32'd0);
        chk("bad_cmd_ha",  {24'd0, bus.ha},  32'd0);
        chk("bad_cmd_mka", {24'd0, bus.mka}, 32'd0);
        bus.cmd = CMD_IDLE;
        @(negedge clk);

        // LOAD_H
        issue(CMD_LOAD_H, CMD_LOAD_H, 1'b0, lat);
        chk("load_latency", lat, 32'd9);
        for (int i = 0; i < 8; i++) chk($sformatf("load_reg%0d", i), dut_reg(i), H_INIT[i]);
        hold_release("load");

        // HASH, with cmd switched to SUM_STORE mid-run
        issue(CMD_HASH, CMD_SUM_STORE, 1'b0, lat);
        chk("hash_latency", lat, 32'd65);
        for (int i = 0; i < 8; i++) chk($sformatf("hash_reg%0d", i), dut_reg(i), H_HASH[i]);
        hold_release("hash");
        chk("hash_reg0_after_done", dut.a, H_HASH[0]);

        // SUM_STORE, with cmd switched to HASH mid-run
        issue(CMD_SUM_STORE, CMD_HASH, 1'b1, lat);
        chk("sum_latency", lat, 32'd9);
        for (int i = 0; i < 8; i++) chk($sformatf("sum_h%0d", i + 8), hmem[i + 8], H_SUM[i]);
        for (int i = 0; i < 8; i++) chk($sformatf("sum_reg%0d", i), dut_reg(i), H_HASH[i]);
        hold_release("sum");

        // Reset at HASH round 30
        bus.cmd = CMD_HASH;
        hit30 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.mka == 8'd30) begin
                hit30 = 1'b1;
                break;
            end
        end
        chk("reach_round30", {31'd0, hit30}, 32'd1);
        reset_n = 1'b0;
        bus.cmd = CMD_IDLE;
        @(negedge clk);
        chk("midrst_rdy", {31'd0, bus.rdy}, 32'd0);
        chk("midrst_mka", {24'd0, bus.mka}, 32'd0);
        chk("midrst_ha",  {24'd0, bus.ha},  32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("midrst_reg%0d", i), dut_reg(i), 32'd0);
        chk("midrst_win15", dut.w_win[15], 32'd0);
        chk("midrst_win0",  dut.w_win[0],  32'd0);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= bus.rdy;
        end
        chk("midrst_no_rdy", {31'd0, seen}, 32'd0);

        // Accepts a fresh command after the abort
        issue(CMD_LOAD_H, CMD_LOAD_H, 1'b0, lat);
        chk("reload_latency", lat, 32'd9);
        chk("reload_reg0", dut.a, H_INIT[0]);
        chk("reload_reg7", dut.h, H_INIT[7]);
        hold_release("reload");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
